// File: rtl/cla_adder.sv
// Registered two-level carry-lookahead adder: 4-bit lookahead groups feeding a group-level lookahead unit.
// Optional signed-overflow output Ovf is built only when CLA_OVERFLOW_EN is defined.
module cla_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             out_valid
`ifdef CLA_OVERFLOW_EN
  ,
  output logic             Ovf
`endif
);

  localparam int NG = WIDTH / 4;

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_c;
  logic [WIDTH-1:0] w_sum;
  logic [NG-1:0]    w_gg;
  logic [NG-1:0]    w_gp;
  logic [NG:0]      w_gc;

  assign w_g   = A & B;
  assign w_p   = A ^ B;
  assign w_sum = w_p ^ w_c;

  for (genvar k = 0; k < NG; k++) begin : g_group
    logic [3:0] w_gl;
    logic [3:0] w_pl;
    logic       w_ci;

    assign w_gl = w_g[4*k +: 4];
    assign w_pl = w_p[4*k +: 4];
    assign w_ci = w_gc[k];

    // Each bit carry is a flat sum of products of group inputs and the group carry-in.
    assign w_c[4*k]   = w_ci;
    assign w_c[4*k+1] = w_gl[0] | (w_pl[0] & w_ci);
    assign w_c[4*k+2] = w_gl[1] | (w_pl[1] & w_gl[0]) | (w_pl[1] & w_pl[0] & w_ci);
    assign w_c[4*k+3] = w_gl[2] | (w_pl[2] & w_gl[1]) | (w_pl[2] & w_pl[1] & w_gl[0])
                      | (w_pl[2] & w_pl[1] & w_pl[0] & w_ci);

    assign w_gg[k] = w_gl[3] | (w_pl[3] & w_gl[2]) | (w_pl[3] & w_pl[2] & w_gl[1])
                   | (w_pl[3] & w_pl[2] & w_pl[1] & w_gl[0]);
    assign w_gp[k] = &w_pl;
  end

  // Second-level lookahead: group carry k is the OR over every lower group j of
  // GG[j] propagated through GP[j+1..k-1], plus Cin propagated through GP[0..k-1].
  always_comb begin
    logic acc;
    logic term;
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_gc    = '0;
    w_gc[0] = Cin;
    for (int k = 1; k <= NG; k++) begin
      acc = Cin;
      for (int m = 0; m < k; m++) acc = acc & w_gp[m];
      for (int j = 0; j < k; j++) begin
        term = w_gg[j];
        for (int m = j + 1; m < k; m++) term = term & w_gp[m];
        acc = acc | term;
      end
      w_gc[k] = acc;
    end
  end

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_valid;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_gc[NG];
      end
    end
  end

  assign Sum       = r_sum;
  assign Cout      = r_cout;
  assign out_valid = r_valid;

`ifdef CLA_OVERFLOW_EN
  logic w_ovf;
  logic r_ovf;

  assign w_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_ovf <= 1'b0;
    else if (in_valid) r_ovf <= w_ovf;
  end

  assign Ovf = r_ovf;
`endif

endmodule

// File: tb/tb_cla_adder.sv
// Directed and random self-checking bench for cla_adder (WIDTH=16); overflow checks
// are compiled in when CLA_OVERFLOW_EN is defined.
module tb_cla_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] A, B;
  logic        Cin, in_valid;
  logic [15:0] Sum;
  logic        Cout, out_valid;
`ifdef CLA_OVERFLOW_EN
  logic        Ovf;
`endif

  int checks = 0;
  int errors = 0;

  cla_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Cin(Cin), .in_valid(in_valid),
    .Sum(Sum), .Cout(Cout), .out_valid(out_valid)
`ifdef CLA_OVERFLOW_EN
    , .Ovf(Ovf)
`endif
  );

  always #5 clk = ~clk;

  // Drive on the falling edge, then sample 1 time unit after the following rising edge.
  task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic c, input logic v);
    @(negedge clk);
    A = a; B = b; Cin = c; in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; A = 16'h1111; B = 16'h2222; Cin = 1'b1; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (Sum !== 16'h0 || Cout !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: Sum=%h Cout=%b out_valid=%b, want 0000 0 0", Sum, Cout, out_valid);
    end
    // Release with in_valid held high: the first rising edge afterwards must capture.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (Sum !== 16'h3334 || Cout !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_capture: Sum=%h Cout=%b out_valid=%b, want 3334 0 1", Sum, Cout, out_valid);
    end
  endtask

  task automatic test_directed;
    logic [15:0] va [6] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h0FFF, 16'h00F0, 16'h8421};
    logic [15:0] vb [6] = '{16'h0001, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0010, 16'h7BDE};
    logic        vc [6] = '{1'b0,     1'b1,     1'b1,     1'b0,     1'b0,     1'b1};
    logic [15:0] es [6] = '{16'h0000, 16'h0000, 16'hFFFF, 16'h1000, 16'h0100, 16'h0000};
    logic        ec [6] = '{1'b1,     1'b1,     1'b1,     1'b0,     1'b0,     1'b1};
    for (int i = 0; i < 6; i++) begin
      apply(va[i], vb[i], vc[i], 1'b1);
      checks++;
      if (Sum !== es[i] || Cout !== ec[i] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL directed_%0d: Sum=%h Cout=%b out_valid=%b, want %h %b 1",
                 i, Sum, Cout, out_valid, es[i], ec[i]);
      end
`ifdef CLA_OVERFLOW_EN
      checks++;
      if (Ovf !== 1'b0) begin
        errors++;
        $display("FAIL directed_ovf_%0d: Ovf=%b, want 0", i, Ovf);
      end
`endif
    end
  endtask

  task automatic test_back_to_back;
    apply(16'h1234, 16'h5678, 1'b1, 1'b1);
    checks++;
    if (Sum !== 16'h68AD || Cout !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: Sum=%h Cout=%b out_valid=%b, want 68AD 0 1", Sum, Cout, out_valid);
    end
    apply(16'hABCD, 16'h4321, 1'b0, 1'b1);
    checks++;
    if (Sum !== 16'hEEEE || Cout !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: Sum=%h Cout=%b out_valid=%b, want EEEE 0 1", Sum, Cout, out_valid);
    end
  endtask

`ifdef CLA_OVERFLOW_EN
  task automatic test_overflow;
    apply(16'h7FFF, 16'h0001, 1'b0, 1'b1);
    checks++;
    if (Sum !== 16'h8000 || Cout !== 1'b0 || Ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_pos: Sum=%h Cout=%b Ovf=%b, want 8000 0 1", Sum, Cout, Ovf);
    end
    apply(16'h8000, 16'h8000, 1'b0, 1'b1);
    checks++;
    if (Sum !== 16'h0000 || Cout !== 1'b1 || Ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_neg: Sum=%h Cout=%b Ovf=%b, want 0000 1 1", Sum, Cout, Ovf);
    end
  endtask
`endif

  task automatic test_hold;
    apply(16'h0102, 16'h0304, 1'b0, 1'b1);
    checks++;
    if (Sum !== 16'h0406 || Cout !== 1'b0) begin
      errors++;
      $display("FAIL hold_load: Sum=%h Cout=%b, want 0406 0", Sum, Cout);
    end
    for (int i = 0; i < 3; i++) begin
      apply(16'hFFFF - 16'(i), 16'hF000, 1'b1, 1'b0);
      checks++;
      if (Sum !== 16'h0406 || Cout !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: Sum=%h Cout=%b out_valid=%b, want 0406 0 0", i, Sum, Cout, out_valid);
      end
    end
  endtask

  task automatic test_mid_reset;
    apply(16'hF00F, 16'h1FF1, 1'b0, 1'b1);
    checks++;
    if (Sum !== 16'h1000 || Cout !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_load: Sum=%h Cout=%b out_valid=%b, want 1000 1 1", Sum, Cout, out_valid);
    end
    // Another valid vector is in flight when reset drops between edges.
    @(negedge clk);
    A = 16'h2222; B = 16'h3333; Cin = 1'b0; in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (Sum !== 16'h0 || Cout !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: Sum=%h Cout=%b out_valid=%b, want 0000 0 0", Sum, Cout, out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (Sum !== 16'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_held: Sum=%h out_valid=%b, want 0000 0", Sum, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (Sum !== 16'h0 || Cout !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_release: Sum=%h Cout=%b out_valid=%b, want 0000 0 0", Sum, Cout, out_valid);
    end
  endtask

  task automatic test_random;
    logic [15:0] a, b, exp_sum;
    logic        c, v, exp_cout;
    logic [16:0] full;
`ifdef CLA_OVERFLOW_EN
    logic        exp_ovf = 1'b0;
`endif
    int          bad = 0;
    exp_sum = Sum; exp_cout = Cout;
    for (int i = 0; i < 10000; i++) begin
      a = 16'($urandom); b = 16'($urandom); c = 1'($urandom); v = 1'($urandom_range(0, 1));
      apply(a, b, c, v);
      if (v) begin
        full     = {1'b0, a} + {1'b0, b} + {16'h0, c};
        exp_sum  = full[15:0];
        exp_cout = full[16];
`ifdef CLA_OVERFLOW_EN
        exp_ovf  = (a[15] == b[15]) && (exp_sum[15] != a[15]);
`endif
      end
      checks++;
      if (Sum !== exp_sum || Cout !== exp_cout || out_valid !== v
`ifdef CLA_OVERFLOW_EN
          || Ovf !== exp_ovf
`endif
         ) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_%0d: A=%h B=%h Cin=%b v=%b got Sum=%h Cout=%b ov=%b, want %h %b %b",
                   i, a, b, c, v, Sum, Cout, out_valid, exp_sum, exp_cout, v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
`ifdef CLA_OVERFLOW_EN
    test_overflow();
`endif
    test_hold();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cla_adder.md
CLA_ADDER -- requirements
Module: cla_adder

Interface
REQ-001 Parameter: WIDTH, default 16, operand/sum width; SHALL be a positive multiple of 4.
REQ-002 Port: clk  input  1  sole clock, rising-edge active.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: A  input  WIDTH  addend A, unsigned (two's complement when CLA_OVERFLOW_EN).
REQ-005 Port: B  input  WIDTH  addend B.
REQ-006 Port: Cin  input  1  carry-in.
REQ-007 Port: in_valid  input  1  A/B/Cin qualify this cycle.
REQ-008 Port: Sum  output  WIDTH  registered sum.
REQ-009 Port: Cout  output  1  registered carry-out.
REQ-010 Port: out_valid  output  1  Sum/Cout hold a new result.
REQ-011 Port: Ovf  output  1  registered signed overflow; present only when CLA_OVERFLOW_EN is defined.

Function
REQ-012 {Cout, Sum} SHALL equal A + B + Cin, computed at WIDTH+1 bits, with no truncation of the carry.
REQ-013 Bit level SHALL compute g[i] = A[i]&B[i], p[i] = A[i]^B[i], and s[i] = p[i]^c[i].
REQ-014 Carries inside each 4-bit group SHALL come from lookahead equations in group inputs and group carry-in only; no ripple between bits.
REQ-015 Each group SHALL produce a group generate GG and a group propagate GP.
REQ-016 A second-level lookahead unit SHALL derive every group carry-in from GG/GP and Cin; no ripple between groups.
REQ-017 Cout SHALL be the carry out of the top group.
REQ-018 On a rising clk with in_valid=1, Sum, Cout (and Ovf) SHALL load the combinational result; latency is exactly 1 cycle.
REQ-019 On a rising clk with in_valid=0, Sum/Cout/Ovf SHALL hold their previous values.
REQ-020 out_valid SHALL be registered in_valid: high for exactly the cycles following accepted inputs.
REQ-021 Back-to-back in_valid SHALL give one result per cycle; there is no stall or backpressure.
REQ-022 Wrap-around: an all-ones operand plus 1 SHALL give Sum=0 and Cout=1.
REQ-023 Maximum case: all-ones + all-ones + 1 SHALL give Sum=all-ones and Cout=1.

Reset
REQ-024 rst_n=0 SHALL immediately force Sum=0, Cout=0, out_valid=0 and Ovf=0, without waiting for clk.
REQ-025 While rst_n=0, inputs SHALL be ignored.
REQ-026 A result in flight when reset asserts SHALL be discarded.
REQ-027 The first capture after reset SHALL occur on the first rising clk at which rst_n=1 and in_valid=1.

Configuration
REQ-028 Macro CLA_OVERFLOW_EN defined: port Ovf SHALL exist and register (A[MSB]==B[MSB]) && (Sum[MSB]!=A[MSB]) under the same enable and reset as Sum.
REQ-029 Macro CLA_OVERFLOW_EN undefined: port Ovf and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-030 A=FFFF, B=0001, Cin=0, in_valid=1 -> next cycle Sum=0000, Cout=1, out_valid=1.
REQ-031 A=1234, B=5678, Cin=1 -> Sum=68AD, Cout=0; then A=ABCD, B=4321, Cin=0 on the next cycle -> Sum=EEEE, Cout=0 (back-to-back).
REQ-032 A=0000, B=FFFF, Cin=1 -> Sum=0000, Cout=1; A=FFFF, B=FFFF, Cin=1 -> Sum=FFFF, Cout=1.
REQ-033 CLA_OVERFLOW_EN: A=7FFF, B=0001, Cin=0 -> Sum=8000, Ovf=1; A=8000, B=8000, Cin=0 -> Sum=0000, Cout=1, Ovf=1.
REQ-034 Drive valid inputs, then pull rst_n low mid-cycle -> outputs go to 0 immediately and no stale out_valid appears after release.
REQ-035 Hold in_valid=0 with changing A/B -> outputs hold and out_valid=0.
REQ-036 Random run of 10k vectors with in_valid toggling -> every result matches A+B+Cin one cycle later.
